// File: rtl/cache_arb_pkg.sv
// ---------------------------------------------------------------------------
// cache_arb_pkg
// Shared types for the cache/main-memory arbiter.
//   arb_state_e : arbiter FSM states (IDLE, XFER, DONE)
//   OWNER_I/D   : encoding of the Owner output / last-owner flop
// ---------------------------------------------------------------------------
package cache_arb_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_XFER = 2'd1,
        ARB_DONE = 2'd2
    } arb_state_e;

    localparam logic OWNER_I = 1'b0;
    localparam logic OWNER_D = 1'b1;

    // Mask that clears the byte offset plus the word-in-line index bits.
    function automatic logic [31:0] line_base_mask(input int cnt_w);
        return ~((32'd1 << (cnt_w + 2)) - 32'd1);
    endfunction

endpackage

// File: rtl/arb_pick.sv
// ---------------------------------------------------------------------------
// arb_pick
// Combinational winner select between the I-cache and D-cache requesters.
// Build option: ARB_ROUND_ROBIN_EN
//   defined   : a tie goes to the side not granted last (i_last_owner)
//   undefined : fixed priority, D over I; i_last_owner port is absent
// Ports:
//   i_last_owner : side granted most recently (round-robin build only)
//   i_ireq       : I-side request
//   i_dreq       : D-side request
//   o_valid      : at least one request present
//   o_owner      : winning side (OWNER_I / OWNER_D)
// ---------------------------------------------------------------------------
module arb_pick
    import cache_arb_pkg::*;
(
`ifdef ARB_ROUND_ROBIN_EN
    input  logic i_last_owner,
`endif
    input  logic i_ireq,
    input  logic i_dreq,
    output logic o_valid,
    output logic o_owner
);

    always_comb begin
        o_valid = i_ireq | i_dreq;
        o_owner = OWNER_I;
`ifdef ARB_ROUND_ROBIN_EN
        if (i_ireq && i_dreq) begin
            o_owner = ~i_last_owner;
        end else if (i_dreq) begin
            o_owner = OWNER_D;
        end
`else
        if (i_dreq) begin
            o_owner = OWNER_D;
        end
`endif
    end

endmodule

// File: rtl/cache_mem_arbiter.sv
// ---------------------------------------------------------------------------
// cache_mem_arbiter
// Shares the single main-memory port between the I-cache refill path and the
// D-cache refill/writeback path. One owner at a time runs a LINE_WORDS burst;
// every word is handed over with a MemReq/MemAck handshake.
// Build option: ARB_ROUND_ROBIN_EN (round-robin tie break, see arb_pick).
// Ports:
//   CPU_CLK, CPU_RST            : clock, synchronous active-high reset
//   IReq/IAddr                  : I-side line read request (held to IDone)
//   IRdData/IRdValid/IDone      : I-side refill words and completion pulse
//   DReq/DWe/DAddr/DWrData      : D-side line read/write request (held to DDone)
//   WordIdx/DWrReady            : current word index, write word consumed
//   DRdData/DRdValid/DDone      : D-side refill words and completion pulse
//   MemReq/MemWe/MemAddr/MemWrData/MemAck/MemRdData : memory word port
//   Busy/Owner                  : burst in progress / owning side
//   o_dbg_state                 : current FSM state
// ---------------------------------------------------------------------------
module cache_mem_arbiter
    import cache_arb_pkg::*;
#(
    parameter int LINE_WORDS = 8,
    parameter int CNT_W      = $clog2(LINE_WORDS)
) (
    input  logic             CPU_CLK,
    input  logic             CPU_RST,
    input  logic             IReq,
    input  logic [31:0]      IAddr,
    output logic [31:0]      IRdData,
    output logic             IRdValid,
    output logic             IDone,
    input  logic             DReq,
    input  logic             DWe,
    input  logic [31:0]      DAddr,
    input  logic [31:0]      DWrData,
    output logic [CNT_W-1:0] WordIdx,
    output logic             DWrReady,
    output logic [31:0]      DRdData,
    output logic             DRdValid,
    output logic             DDone,
    output logic             MemReq,
    output logic             MemWe,
    output logic [31:0]      MemAddr,
    output logic [31:0]      MemWrData,
    input  logic             MemAck,
    input  logic [31:0]      MemRdData,
    output logic             Busy,
    output logic             Owner,
    output logic [1:0]       o_dbg_state
);

    localparam logic [31:0] BASE_MASK = line_base_mask(CNT_W);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(LINE_WORDS - 1);

    arb_state_e       r_state;
    arb_state_e       w_state_nxt;
    logic [CNT_W-1:0] r_word_idx;
    logic             r_owner;
    logic             r_we;
    logic [31:0]      r_base;

    logic             w_pick_valid;
    logic             w_pick_owner;
    logic             w_xfer;
    logic             w_beat;
    logic [31:0]      w_offset;

    // ------------------------------------------------------------------
    // Winner select
    // ------------------------------------------------------------------
`ifdef ARB_ROUND_ROBIN_EN
    logic r_last_owner;

    always_ff @(posedge CPU_CLK) begin
        if (CPU_RST) begin
            r_last_owner <= OWNER_I;
        end else if (r_state == ARB_IDLE && w_pick_valid) begin
            r_last_owner <= w_pick_owner;
        end
    end

    arb_pick u_pick (
        .i_last_owner (r_last_owner),
        .i_ireq       (IReq),
        .i_dreq       (DReq),
        .o_valid      (w_pick_valid),
        .o_owner      (w_pick_owner)
    );
`else
    arb_pick u_pick (
        .i_ireq  (IReq),
        .i_dreq  (DReq),
        .o_valid (w_pick_valid),
        .o_owner (w_pick_owner)
    );
`endif

    // ------------------------------------------------------------------
    // State register, grant latches and word counter
    // ------------------------------------------------------------------
    always_ff @(posedge CPU_CLK) begin
        if (CPU_RST) begin
            r_state    <= ARB_IDLE;
            r_word_idx <= '0;
            r_owner    <= OWNER_I;
            r_we       <= 1'b0;
            r_base     <= '0;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                ARB_IDLE: begin
                    if (w_pick_valid) begin
                        r_owner    <= w_pick_owner;
                        r_we       <= (w_pick_owner == OWNER_D) ? DWe : 1'b0;
                        r_base     <= ((w_pick_owner == OWNER_D) ? DAddr : IAddr) & BASE_MASK;
                        r_word_idx <= '0;
                    end
                end
                ARB_XFER: begin
                    // Power-of-2 line: the natural counter wrap lands on 0
                    // exactly when the last word is acked.
                    if (MemAck) begin
                        r_word_idx <= r_word_idx + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Next state
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ARB_IDLE: if (w_pick_valid) w_state_nxt = ARB_XFER;
            ARB_XFER: if (MemAck && r_word_idx == LAST_IDX) w_state_nxt = ARB_DONE;
            ARB_DONE: w_state_nxt = ARB_IDLE;
            default:  w_state_nxt = ARB_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs
    // Handshake: in XFER, MemReq/MemWe/MemAddr/MemWrData are held stable
    // until the cycle MemAck is high; that cycle the word transfers, the
    // owner's RdValid (read) or DWrReady (write) pulses alongside it, and
    // the index advances on the following edge. No MemAck timeout.
    // ------------------------------------------------------------------
    assign w_xfer   = (r_state == ARB_XFER);
    assign w_beat   = w_xfer & MemAck;
    assign w_offset = {{(30 - CNT_W){1'b0}}, r_word_idx, 2'b00};

    always_comb begin
        MemReq    = w_xfer;
        MemWe     = w_xfer & r_we;
        MemAddr   = w_xfer ? (r_base + w_offset) : 32'd0;
        MemWrData = (w_xfer && r_we && r_owner == OWNER_D) ? DWrData : 32'd0;

        IRdValid  = w_beat & ~r_we & (r_owner == OWNER_I);
        DRdValid  = w_beat & ~r_we & (r_owner == OWNER_D);
        DWrReady  = w_beat &  r_we & (r_owner == OWNER_D);
        IRdData   = IRdValid ? MemRdData : 32'd0;
        DRdData   = DRdValid ? MemRdData : 32'd0;

        IDone     = (r_state == ARB_DONE) & (r_owner == OWNER_I);
        DDone     = (r_state == ARB_DONE) & (r_owner == OWNER_D);
    end

    assign WordIdx     = r_word_idx;
    assign Busy        = (r_state != ARB_IDLE);
    assign Owner       = r_owner;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_cache_mem_arbiter
// Directed bench for cache_mem_arbiter (LINE_WORDS = 8): I read burst,
// D write burst with wait states, simultaneous requests over two bursts,
// reset mid-burst, request dropped mid-burst.
// ---------------------------------------------------------------------------
module tb_cache_mem_arbiter;
    import cache_arb_pkg::*;

    localparam int LW = 8;
    localparam int CW = 3;

    // ---------------- clock / reset ----------------
    logic CPU_CLK = 1'b0;
    logic CPU_RST;
    always #5 CPU_CLK = ~CPU_CLK;

    logic          IReq, DReq, DWe, MemAck;
    logic [31:0]   IAddr, DAddr, DWrData, MemRdData;
    logic [31:0]   IRdData, DRdData, MemAddr, MemWrData;
    logic          IRdValid, IDone, DWrReady, DRdValid, DDone;
    logic          MemReq, MemWe, Busy, Owner;
    logic [CW-1:0] WordIdx;
    logic [1:0]    dbg_state;

    logic [31:0]   wr_line [LW];
    logic [31:0]   rd_seed;
    logic [31:0]   exp_q [$];
    int            n_cmp = 0;
    int            n_err = 0;

    // D-side supplies the write word selected by the arbiter's index.
    assign DWrData = wr_line[WordIdx];

    cache_mem_arbiter #(.LINE_WORDS(LW)) dut (
        .CPU_CLK     (CPU_CLK),
        .CPU_RST     (CPU_RST),
        .IReq        (IReq),
        .IAddr       (IAddr),
        .IRdData     (IRdData),
        .IRdValid    (IRdValid),
        .IDone       (IDone),
        .DReq        (DReq),
        .DWe         (DWe),
        .DAddr       (DAddr),
        .DWrData     (DWrData),
        .WordIdx     (WordIdx),
        .DWrReady    (DWrReady),
        .DRdData     (DRdData),
        .DRdValid    (DRdValid),
        .DDone       (DDone),
        .MemReq      (MemReq),
        .MemWe       (MemWe),
        .MemAddr     (MemAddr),
        .MemWrData   (MemWrData),
        .MemAck      (MemAck),
        .MemRdData   (MemRdData),
        .Busy        (Busy),
        .Owner       (Owner),
        .o_dbg_state (dbg_state)
    );

    // ---------------- helpers ----------------
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CPU_CLK);
        #1;
    endtask

    task automatic do_reset();
        CPU_RST   = 1'b1;
        IReq      = 1'b0;
        DReq      = 1'b0;
        DWe       = 1'b0;
        IAddr     = 32'd0;
        DAddr     = 32'd0;
        MemAck    = 1'b0;
        MemRdData = 32'd0;
        tick();
        tick();
        CPU_RST = 1'b0;
        #3;
    endtask

    // Entered one cycle after the grant edge (state is XFER). Drives the
    // memory side, checks every word, the DONE cycle and the IDLE gap cycle.
    task automatic run_burst(input string tag, input logic own, input logic we,
                             input logic [31:0] base, input int ack_every,
                             input int drop_after, input logic release_req);
        logic [31:0] e;
        chk({tag, "_busy"}, {31'd0, Busy}, 32'd1);
        chk({tag, "_owner"}, {31'd0, Owner}, {31'd0, own});
        chk({tag, "_state"}, {30'd0, dbg_state}, {30'd0, ARB_XFER});
        for (int b = 0; b < LW; b++) begin
            for (int w = 0; w < ack_every - 1; w++) begin
                MemAck = 1'b0;
                #3;
                chk({tag, "_wait_req"}, {31'd0, MemReq}, 32'd1);
                chk({tag, "_wait_addr"}, MemAddr, base + 32'(b * 4));
                chk({tag, "_wait_valid"}, {29'd0, IRdValid, DRdValid, DWrReady}, 32'd0);
                if (we) chk({tag, "_wait_wdata"}, MemWrData, wr_line[b]);
                tick();
            end
            MemAck    = 1'b1;
            MemRdData = rd_seed + 32'(b);
            if (!we) exp_q.push_back(rd_seed + 32'(b));
            #3;
            chk({tag, "_req"}, {31'd0, MemReq}, 32'd1);
            chk({tag, "_we"}, {31'd0, MemWe}, {31'd0, we});
            chk({tag, "_addr"}, MemAddr, base + 32'(b * 4));
            chk({tag, "_idx"}, {29'd0, WordIdx}, 32'(b));
            chk({tag, "_done_mid"}, {30'd0, IDone, DDone}, 32'd0);
            if (we) begin
                chk({tag, "_wrrdy"}, {31'd0, DWrReady}, 32'd1);
                chk({tag, "_wdata"}, MemWrData, wr_line[b]);
                chk({tag, "_rdv_wr"}, {30'd0, IRdValid, DRdValid}, 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk({tag, "_wrrdy_rd"}, {31'd0, DWrReady}, 32'd0);
                chk({tag, "_wdata_rd"}, MemWrData, 32'd0);
                if (own == OWNER_D) begin
                    chk({tag, "_rdv"}, {30'd0, IRdValid, DRdValid}, 32'd1);
                    chk({tag, "_rdata"}, DRdData, e);
                end else begin
                    chk({tag, "_rdv"}, {30'd0, IRdValid, DRdValid}, 32'd2);
                    chk({tag, "_rdata"}, IRdData, e);
                end
            end
            tick();
            MemAck = 1'b0;
            if (b == drop_after) begin
                if (own == OWNER_D) DReq = 1'b0;
                else IReq = 1'b0;
            end
        end
        // DONE cycle
        #3;
        chk({tag, "_done_req"}, {31'd0, MemReq}, 32'd0);
        chk({tag, "_done"}, {30'd0, IDone, DDone}, (own == OWNER_D) ? 32'd1 : 32'd2);
        chk({tag, "_done_idx"}, {29'd0, WordIdx}, 32'd0);
        if (release_req) begin
            IReq = 1'b0;
            DReq = 1'b0;
        end
        tick();
        // IDLE cycle
        #3;
        chk({tag, "_idle_busy"}, {31'd0, Busy}, 32'd0);
        chk({tag, "_idle_req"}, {31'd0, MemReq}, 32'd0);
        chk({tag, "_idle_done"}, {30'd0, IDone, DDone}, 32'd0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic own2;
        logic [31:0] base2;
        for (int i = 0; i < LW; i++) wr_line[i] = 32'hA000_0000 + 32'(i) * 32'h0101_1111;

        // Reset values
        do_reset();
        chk("rst_busy", {31'd0, Busy}, 32'd0);
        chk("rst_owner", {31'd0, Owner}, 32'd0);
        chk("rst_memreq", {31'd0, MemReq}, 32'd0);
        chk("rst_memaddr", MemAddr, 32'd0);
        chk("rst_idx", {29'd0, WordIdx}, 32'd0);
        chk("rst_state", {30'd0, dbg_state}, {30'd0, ARB_IDLE});

        // 1) I read, ack every cycle
        rd_seed = 32'h1C00_0000;
        tick();
        IReq  = 1'b1;
        IAddr = 32'h0000_1034;
        #3;
        chk("iread_lat0", {31'd0, MemReq}, 32'd0);
        tick();
        run_burst("iread", OWNER_I, 1'b0, 32'h0000_1020, 1, -1, 1'b1);

        // 2) D write, ack every third cycle; address/we changes after grant ignored
        do_reset();
        tick();
        DReq  = 1'b1;
        DWe   = 1'b1;
        DAddr = 32'h0000_2000;
        tick();
        DAddr = 32'hFFFF_FFF0;
        DWe   = 1'b0;
        run_burst("dwrite", OWNER_D, 1'b1, 32'h0000_2000, 3, -1, 1'b1);

        // 3) Simultaneous requests held through two bursts
        do_reset();
        rd_seed = 32'h7700_0000;
        tick();
        IReq  = 1'b1;
        IAddr = 32'h0000_6000;
        DReq  = 1'b1;
        DWe   = 1'b0;
        DAddr = 32'h0000_7000;
        tick();
        run_burst("tie1", OWNER_D, 1'b0, 32'h0000_7000, 1, -1, 1'b0);
`ifdef ARB_ROUND_ROBIN_EN
        own2  = OWNER_I;
        base2 = 32'h0000_6000;
`else
        own2  = OWNER_D;
        base2 = 32'h0000_7000;
`endif
        tick();
        run_burst("tie2", own2, 1'b0, base2, 1, -1, 1'b1);

        // 4) Reset mid-burst at WordIdx=3
        do_reset();
        tick();
        IReq  = 1'b1;
        IAddr = 32'h0000_4008;
        tick();
        for (int b = 0; b < 3; b++) begin
            MemAck = 1'b1;
            tick();
        end
        MemAck = 1'b0;
        #3;
        chk("rstmid_idx3", {29'd0, WordIdx}, 32'd3);
        chk("rstmid_addr3", MemAddr, 32'h0000_400C);
        tick();
        CPU_RST = 1'b1;
        IReq    = 1'b0;
        tick();
        CPU_RST = 1'b0;
        #3;
        chk("rstmid_busy", {31'd0, Busy}, 32'd0);
        chk("rstmid_memreq", {31'd0, MemReq}, 32'd0);
        chk("rstmid_idx", {29'd0, WordIdx}, 32'd0);
        chk("rstmid_done", {30'd0, IDone, DDone}, 32'd0);
        rd_seed = 32'h5500_0000;
        IReq  = 1'b1;
        IAddr = 32'h0000_5010;
        tick();
        run_burst("rst_restart", OWNER_I, 1'b0, 32'h0000_5000, 1, -1, 1'b1);

        // 5) DReq dropped after word 2; burst completes; stray acks in IDLE
        do_reset();
        rd_seed = 32'h3300_0000;
        tick();
        DReq  = 1'b1;
        DWe   = 1'b0;
        DAddr = 32'h0000_3004;
        tick();
        run_burst("ddrop", OWNER_D, 1'b0, 32'h0000_3000, 2, 2, 1'b1);
        tick();
        MemAck = 1'b1;
        #3;
        chk("stray_memreq", {31'd0, MemReq}, 32'd0);
        chk("stray_valid", {29'd0, IRdValid, DRdValid, DWrReady}, 32'd0);
        tick();
        MemAck = 1'b0;
        #3;
        chk("stray_idx", {29'd0, WordIdx}, 32'd0);
        chk("stray_busy", {31'd0, Busy}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
